// File: rtl/perf_cache_event_arb_if.sv
// Event-arbiter bus: requester-side event strobes and sink-side outputs.
interface perf_cache_event_arb_if #(
    parameter int N_REQ = 4
);
    logic                 en;
    logic [N_REQ-1:0]     req_valid;
    logic [8*N_REQ-1:0]   req_id;
    logic [8*N_REQ-1:0]   req_type;
    logic                 out_valid;
    logic [7:0]           out_id;
    logic [7:0]           out_access_type;
    logic [2:0]           out_src;
    logic [15:0]          drop_cnt;
    logic                 busy;

    // Requesters and the event sink side.
    modport master (
        output en, req_valid, req_id, req_type,
        input  out_valid, out_id, out_access_type, out_src, drop_cnt, busy
    );

    // The arbiter itself.
    modport slave (
        input  en, req_valid, req_id, req_type,
        output out_valid, out_id, out_access_type, out_src, drop_cnt, busy
    );
endinterface

// File: rtl/perf_cache_event_arb.sv
// Cache perf-event arbiter: one small FIFO per requester, round-robin drain
// of one event per cycle onto a registered sink port. Events arriving at a
// full FIFO (that is not being popped the same cycle) are dropped and counted.

// Per-requester event FIFO. Accept/drop policy lives in the parent; this
// block just stores whatever it is told to push and pops on request.
module perf_cache_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers wrap naturally (power-of-two depth); count tracks +push -pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; a full FIFO pushed while popped overwrites the
    // slot being read, which is safe because the read is of the old value.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];
endmodule

module perf_cache_event_arb #(
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    perf_cache_event_arb_if.slave   bus
);
    localparam int          SW  = $clog2(N_REQ);
    localparam int          CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [SW:0] N_W = (SW+1)'(N_REQ);

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] access_type;
    } event_t;

    event_t [N_REQ-1:0]          head;
    logic   [N_REQ-1:0][CW-1:0]  count;
    logic   [N_REQ-1:0]          nonempty;
    logic   [N_REQ-1:0]          full;
    logic   [N_REQ-1:0]          push;
    logic   [N_REQ-1:0]          grant;
    logic   [N_REQ-1:0]          dropped;

    logic [SW-1:0] last_grant;
    logic [SW-1:0] grant_idx;
    logic          grant_any;
    logic [SW:0]   cand_sum;
    logic [SW-1:0] cand;
    logic [3:0]    drop_num;
    logic [16:0]   drop_sum;

    logic          out_valid_q;
    event_t        out_q;
    logic [2:0]    out_src_q;
    logic [15:0]   drop_cnt_q;

    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        assign nonempty[g] = (count[g] != '0);
        assign full[g]     = (count[g] == CW'(FIFO_DEPTH));
        // A full FIFO can still take an event in the cycle it is popped.
        assign push[g]     = bus.en & bus.req_valid[g] & (~full[g] | grant[g]);
        assign dropped[g]  = bus.en & bus.req_valid[g] & full[g] & ~grant[g];

        perf_cache_event_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (16)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .pop   (grant[g]),
            .din   ({bus.req_id[8*g +: 8], bus.req_type[8*g +: 8]}),
            .dout  (head[g]),
            .count (count[g])
        );
    end

    // Round-robin pick from registered counts, starting after last_grant.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_sum = {1'b0, last_grant} + (SW+1)'(k);
            if (cand_sum >= N_W) cand_sum = cand_sum - N_W;
            cand = cand_sum[SW-1:0];
            if (!grant_any && nonempty[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // One-hot pop strobe for the chosen FIFO.
    always_comb begin
        grant = '0;
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    // Number of requesters losing an event this cycle.
    always_comb begin
        drop_num = '0;
        for (int i = 0; i < N_REQ; i++) drop_num = drop_num + {3'b000, dropped[i]};
    end

    assign drop_sum = {1'b0, drop_cnt_q} + {13'b0, drop_num};

    // Grant pointer and registered sink port; payload holds when idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant  <= SW'(N_REQ - 1);
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= grant_any;
            if (grant_any) begin
                last_grant <= grant_idx;
                out_q      <= head[grant_idx];
                out_src_q  <= 3'(grant_idx);
            end
        end
    end

    // Saturating drop counter, updated on the edge of the dropped push.
    always_ff @(posedge clk) begin
        if (!rst) drop_cnt_q <= '0;
        else      drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.out_id          = out_q.id;
    assign bus.out_access_type = out_q.access_type;
    assign bus.out_src         = out_src_q;
    assign bus.drop_cnt        = drop_cnt_q;
    assign bus.busy            = |nonempty;
endmodule

// File: tb/tb_perf_cache_event_arb.sv
// Bench for perf_cache_event_arb: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, random traffic.
module tb_perf_cache_event_arb;
    localparam int N = 4;
    localparam int D = 4;

    logic clk;
    logic rst;

    perf_cache_event_arb_if #(.N_REQ(N)) bus ();

    perf_cache_event_arb #(.N_REQ(N), .FIFO_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue of {id,type} per requester.
    logic [15:0] mq [N][$];
    int          m_last;
    logic        m_vld;
    logic [7:0]  m_id;
    logic [7:0]  m_type;
    logic [2:0]  m_src;
    int          m_drop;

    // Emitted events observed on the sink port.
    logic [2:0]  em_src [$];
    logic [7:0]  em_id  [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_grant();
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (mq[j].size() > 0) return j;
        end
        return -1;
    endfunction

    function automatic logic m_busy();
        for (int i = 0; i < N; i++) if (mq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] pack4(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int          g;
        logic [15:0] e;
        if (!rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_last = N - 1;
            m_vld  = 1'b0;
            m_id   = '0;
            m_type = '0;
            m_src  = '0;
            m_drop = 0;
            return;
        end
        g = m_grant();
        m_vld = (g >= 0);
        if (g >= 0) begin
            e      = mq[g].pop_front();
            m_id   = e[15:8];
            m_type = e[7:0];
            m_src  = 3'(g);
            m_last = g;
        end
        if (bus.en) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i]) begin
                    if (mq[i].size() < D) mq[i].push_back({bus.req_id[8*i +: 8], bus.req_type[8*i +: 8]});
                    else if (m_drop < 65535) m_drop++;
                end
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", bus.out_valid, m_vld);
        chk("out_id", bus.out_id, m_id);
        chk("out_access_type", bus.out_access_type, m_type);
        chk("out_src", bus.out_src, m_src);
        chk("drop_cnt", bus.drop_cnt, m_drop);
        chk("busy", bus.busy, m_busy());
    endtask

    // Drive one cycle, step model, then sample on the falling edge.
    task automatic cyc(input logic r, input logic e, input logic [3:0] v,
                       input logic [31:0] ids, input logic [31:0] tys);
        rst           = r;
        bus.en        = e;
        bus.req_valid = v;
        bus.req_id    = ids;
        bus.req_type  = tys;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
        if (bus.out_valid === 1'b1) begin
            em_src.push_back(bus.out_src);
            em_id.push_back(bus.out_id);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 4'b0000, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b1, 4'b0000, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 4'b0000, 32'h0, 32'h0);
        em_src.delete();
        em_id.delete();
    endtask

    initial begin
        logic [7:0] q0 [$];
        int         g;
        int         need;
        int         nd;
        logic [3:0] mask;

        rst = 1'b0;
        bus.en = 1'b1;
        bus.req_valid = '0;
        bus.req_id = '0;
        bus.req_type = '0;

        // Reset state and single event
        do_reset();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_id", bus.out_id, 0);
        chk("rst_out_src", bus.out_src, 0);
        chk("rst_drop", bus.drop_cnt, 0);
        chk("rst_busy", bus.busy, 0);
        cyc(1'b1, 1'b1, 4'b0100, pack4(8'h0, 8'h0, 8'h21, 8'h0), pack4(8'h0, 8'h0, 8'h03, 8'h0));
        chk("single_t_valid", bus.out_valid, 0);
        chk("single_t_busy", bus.busy, 1);
        idle(1);
        chk("single_t2_valid", bus.out_valid, 1);
        chk("single_t2_id", bus.out_id, 8'h21);
        chk("single_t2_type", bus.out_access_type, 8'h03);
        chk("single_t2_src", bus.out_src, 2);
        chk("single_t2_busy", bus.busy, 0);
        idle(1);
        chk("single_t3_valid", bus.out_valid, 0);
        chk("single_t3_hold_id", bus.out_id, 8'h21);

        // Round-robin fairness
        do_reset();
        cyc(1'b1, 1'b1, 4'b1111, pack4(8'h10, 8'h11, 8'h12, 8'h13), 32'h0);
        for (int k = 0; k < N; k++) begin
            idle(1);
            chk("rr_valid", bus.out_valid, 1);
            chk("rr_src", bus.out_src, k);
            chk("rr_id", bus.out_id, 8'h10 + k);
        end
        idle(1);
        chk("rr_done_valid", bus.out_valid, 0);
        cyc(1'b1, 1'b1, 4'b1010, pack4(8'h0, 8'h31, 8'h0, 8'h33), 32'h0);
        idle(1);
        chk("rr2_src_a", bus.out_src, 1);
        chk("rr2_id_a", bus.out_id, 8'h31);
        idle(1);
        chk("rr2_src_b", bus.out_src, 3);
        chk("rr2_id_b", bus.out_id, 8'h33);

        // Overflow: req 0 pushes ids 1..6, others keep RR busy; id 6 is lost
        do_reset();
        cyc(1'b1, 1'b1, 4'b1110, pack4(8'h0, 8'h81, 8'h82, 8'h83), 32'h0);
        cyc(1'b1, 1'b1, 4'b1110, pack4(8'h0, 8'h91, 8'h92, 8'h93), 32'h0);
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b1, 1'b1, 4'b0001, pack4(8'(k), 8'h0, 8'h0, 8'h0), 32'h0);
            if (k == 5) chk("ovf_drop_before", bus.drop_cnt, 0);
        end
        chk("ovf_drop", bus.drop_cnt, 1);
        idle(10);
        q0.delete();
        foreach (em_src[i]) if (em_src[i] == 3'd0) q0.push_back(em_id[i]);
        chk("ovf_n_emitted", q0.size(), 5);
        foreach (q0[i]) chk("ovf_order", q0[i], i + 1);

        // Full FIFO pushed in the cycle it is granted
        do_reset();
        cyc(1'b1, 1'b1, 4'b1111, pack4(8'h40, 8'h51, 8'h52, 8'h53), 32'h0);
        cyc(1'b1, 1'b1, 4'b1111, pack4(8'h01, 8'h61, 8'h62, 8'h63), 32'h0);
        for (int k = 2; k <= 4; k++) cyc(1'b1, 1'b1, 4'b0001, pack4(8'(k), 8'h0, 8'h0, 8'h0), 32'h0);
        chk("full_model_cnt", mq[0].size(), 4);
        cyc(1'b1, 1'b1, 4'b0001, pack4(8'h05, 8'h0, 8'h0, 8'h0), 32'h0);
        chk("full_pop_drop", bus.drop_cnt, 0);
        idle(10);
        q0.delete();
        foreach (em_src[i]) if (em_src[i] == 3'd0) q0.push_back(em_id[i]);
        chk("full_n_emitted", q0.size(), 6);
        if (q0.size() == 6) begin
            chk("full_first", q0[0], 8'h40);
            for (int i = 1; i < 6; i++) chk("full_order", q0[i], i);
        end

        // en gating
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 4'b1111, $urandom, $urandom);
            chk("en_valid", bus.out_valid, 0);
            chk("en_drop", bus.drop_cnt, 0);
            chk("en_busy", bus.busy, 0);
        end

        // Drop counter saturation: steer drops onto 16'hFFFE, then 3 more
        do_reset();
        while (m_drop < 16'hFFFE) begin
            g    = m_grant();
            need = 16'hFFFE - m_drop;
            nd   = 0;
            mask = '0;
            for (int i = 0; i < N; i++) begin
                if (mq[i].size() < D || i == g) mask[i] = 1'b1;
                else if (nd < need) begin
                    mask[i] = 1'b1;
                    nd++;
                end
            end
            cyc(1'b1, 1'b1, mask, $urandom, $urandom);
        end
        chk("sat_pre", bus.drop_cnt, 16'hFFFE);
        cyc(1'b1, 1'b1, 4'b1111, $urandom, $urandom);
        chk("sat_hit", bus.drop_cnt, 16'hFFFF);
        cyc(1'b1, 1'b1, 4'b1111, $urandom, $urandom);
        chk("sat_hold", bus.drop_cnt, 16'hFFFF);

        // Reset mid-operation with three events queued per requester
        do_reset();
        cyc(1'b1, 1'b1, 4'b1111, $urandom, $urandom);
        cyc(1'b1, 1'b1, 4'b1111, $urandom, $urandom);
        cyc(1'b1, 1'b1, 4'b1111, $urandom, $urandom);
        cyc(1'b1, 1'b1, 4'b0011, $urandom, $urandom);
        cyc(1'b1, 1'b1, 4'b1100, $urandom, $urandom);
        for (int i = 0; i < N; i++) chk("mid_fill", mq[i].size(), 3);
        chk("mid_busy_pre", bus.busy, 1);
        cyc(1'b0, 1'b1, 4'b0000, 32'h0, 32'h0);
        chk("mid_valid", bus.out_valid, 0);
        chk("mid_busy", bus.busy, 0);
        em_src.delete();
        em_id.delete();
        idle(6);
        chk("mid_none_emitted", em_src.size(), 0);
        cyc(1'b1, 1'b1, 4'b1000, pack4(8'h0, 8'h0, 8'h0, 8'h77), pack4(8'h0, 8'h0, 8'h0, 8'h05));
        chk("mid_next_t_valid", bus.out_valid, 0);
        idle(1);
        chk("mid_next_valid", bus.out_valid, 1);
        chk("mid_next_src", bus.out_src, 3);
        chk("mid_next_id", bus.out_id, 8'h77);

        // Random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            cyc(($urandom_range(0, 249) != 0), ($urandom_range(0, 9) != 0),
                4'($urandom_range(0, 15)), $urandom, $urandom);
        end
        idle(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
